// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and the forward muxes:
// forward selects, md_op, Tnew/Tuse codes, the E-stage shadow record and hit helpers.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_ORIGIN = 2'b00,
        FWD_M      = 2'b01,
        FWD_W      = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_HILO = 2'b11
    } md_op_e;

    localparam logic [1:0] TNEW_PC8  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        md_op_e     md_op;
    } e_stage_t;

    // Producer in E or M cannot deliver before the consumer needs it; $0 never hazards.
    function automatic logic data_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_a3) && (tuse < e_tnew)) ||
                ((src == m_a3) && (tuse < m_tnew)));
    endfunction

    // M wins over W; an M hit is only usable once its result exists (Tnew reached 0).
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] src,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        if ((src != 5'd0) && (m_a3 != 5'd0) && (src == m_a3) && (m_tnew == TNEW_PC8))
            return FWD_M;
        else if ((src != 5'd0) && (w_a3 != 5'd0) && (src == w_a3))
            return FWD_W;
        else
            return FWD_ORIGIN;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter: loads the op latency when a mult/div
// enters E and counts down to zero; md_busy is high while it is nonzero.
module md_busy_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (start_mult)
            cnt <= CNT_W'(MULT_LAT);
        else if (start_div)
            cnt <= CNT_W'(DIV_LAT);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: E/M/W shadow pipeline, stall generation,
// forward-mux selects for D and E, and the mult/div busy counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic [1:0] D_md_op,
    output logic       stall,
    output logic [1:0] FwdSel_D_rs,
    output logic [1:0] FwdSel_D_rt,
    output logic [1:0] FwdSel_E_rs,
    output logic [1:0] FwdSel_E_rt,
    output logic       md_busy
);

    e_stage_t   e_q;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic [4:0] w_a3;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic start_mult;
    logic start_div;

    assign stall_rs = data_hazard(D_rs, D_Tuse_rs, e_q.a3, e_q.tnew, m_a3, m_tnew);
    assign stall_rt = data_hazard(D_rt, D_Tuse_rt, e_q.a3, e_q.tnew, m_a3, m_tnew);
    assign stall_md = (D_md_op != MD_NONE) && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;

    assign FwdSel_D_rs = fwd_select(D_rs,   m_a3, m_tnew, w_a3);
    assign FwdSel_D_rt = fwd_select(D_rt,   m_a3, m_tnew, w_a3);
    assign FwdSel_E_rs = fwd_select(e_q.rs, m_a3, m_tnew, w_a3);
    assign FwdSel_E_rt = fwd_select(e_q.rt, m_a3, m_tnew, w_a3);

    // The counter loads only on the edge where the op actually advances into E.
    assign start_mult = !stall && (D_md_op == MD_MULT);
    assign start_div  = !stall && (D_md_op == MD_DIV);

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q    <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
        end else begin
            // A mult/div sitting in E must always be covered by the busy counter.
            assert (!((e_q.md_op == MD_MULT) || (e_q.md_op == MD_DIV)) || md_busy);
            if (stall)
                e_q <= '0;
            else
                e_q <= '{rs: D_rs, rt: D_rt, a3: D_A3, tnew: D_Tnew,
                         md_op: md_op_e'(D_md_op)};
            m_a3   <= e_q.a3;
            m_tnew <= (e_q.tnew == TNEW_PC8) ? TNEW_PC8 : e_q.tnew - 2'd1;
            w_a3   <= m_a3;
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .md_busy    (md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew, D_md_op;
    logic       stall, md_busy;
    logic [1:0] FwdSel_D_rs, FwdSel_D_rt, FwdSel_E_rs, FwdSel_E_rt;

    typedef struct {
        logic       stall;
        logic [1:0] fdrs;
        logic [1:0] fdrt;
        logic [1:0] fers;
        logic [1:0] fert;
        logic       busy;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_Tuse_rs   (D_Tuse_rs),
        .D_Tuse_rt   (D_Tuse_rt),
        .D_A3        (D_A3),
        .D_Tnew      (D_Tnew),
        .D_md_op     (D_md_op),
        .stall       (stall),
        .FwdSel_D_rs (FwdSel_D_rs),
        .FwdSel_D_rt (FwdSel_D_rt),
        .FwdSel_E_rs (FwdSel_E_rs),
        .FwdSel_E_rt (FwdSel_E_rt),
        .md_busy     (md_busy)
    );

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.name, ".stall"},       {1'b0, stall},   {1'b0, e.stall});
            check({e.name, ".FwdSel_D_rs"}, FwdSel_D_rs,     e.fdrs);
            check({e.name, ".FwdSel_D_rt"}, FwdSel_D_rt,     e.fdrt);
            check({e.name, ".FwdSel_E_rs"}, FwdSel_E_rs,     e.fers);
            check({e.name, ".FwdSel_E_rt"}, FwdSel_E_rt,     e.fert);
            check({e.name, ".md_busy"},     {1'b0, md_busy}, {1'b0, e.busy});
        end
    end

    // Drive one D-stage instruction for one cycle and queue its expected outputs.
    task automatic step(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [1:0] tur, input logic [1:0] tut,
        input logic [4:0] a3, input logic [1:0] tnew, input logic [1:0] md,
        input logic x_stall, input logic [1:0] x_fdrs, input logic [1:0] x_fdrt,
        input logic [1:0] x_fers, input logic [1:0] x_fert, input logic x_busy,
        input string nm
    );
        exp_t e;
        D_rs = rs; D_rt = rt; D_Tuse_rs = tur; D_Tuse_rt = tut;
        D_A3 = a3; D_Tnew = tnew; D_md_op = md;
        e.stall = x_stall; e.fdrs = x_fdrs; e.fdrt = x_fdrt;
        e.fers = x_fers; e.fert = x_fert; e.busy = x_busy; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic busy, input string nm);
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, busy, nm);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset held for two edges with a live-looking instruction in D.
        #1;
        reset = 1'b0;
        D_rs = 5'd5; D_rt = 5'd0; D_Tuse_rs = 2'd1; D_Tuse_rt = 2'd3;
        D_A3 = 5'd5; D_Tnew = 2'd1; D_md_op = 2'b00;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        step(5, 0, 1, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, "reset_release");
        nop(0, "rst_nop1"); nop(0, "rst_nop2"); nop(0, "rst_nop3");

        // Load-use: lw $8 then add rs=8 (Tuse 1): one stall, then W forward in E.
        step(29, 0, 1, 3, 8, 2, 0, 0, 0, 0, 0, 0, 0, "lu_lw");
        step(8, 9, 1, 1, 10, 1, 0, 1, 0, 0, 0, 0, 0, "lu_add_stall");
        step(8, 9, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, "lu_add_go");
        step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, "lu_add_in_E");
        nop(0, "lu_n1"); nop(0, "lu_n2"); nop(0, "lu_n3");

        // ALU-ALU chain: no stall, M forward to D and E, W forward next cycle.
        step(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, "aa_addu");
        step(3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "aa_subu");
        step(3, 5, 1, 1, 6, 1, 0, 0, 2'b01, 0, 2'b01, 0, 0, "aa_or");
        step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, "aa_or_in_E");
        nop(0, "aa_n1"); nop(0, "aa_n2"); nop(0, "aa_n3");

        // Same register in M and W: M must win.
        step(1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, "pr_addu1");
        step(1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, "pr_addu2");
        step(7, 7, 1, 1, 9, 1, 0, 0, 2'b01, 2'b01, 0, 0, 0, "pr_sub_D");
        step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, "pr_sub_E");
        nop(0, "pr_n1"); nop(0, "pr_n2"); nop(0, "pr_n3");

        // Branch after ALU: one stall, then M forward into the D compare.
        step(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, "br_addu");
        step(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "br_beq_stall");
        step(4, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, "br_beq_go");
        step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, "br_beq_in_E");
        nop(0, "br_n1"); nop(0, "br_n2");

        // Branch after load: two stalls, then W forward into D.
        step(29, 0, 1, 3, 11, 2, 0, 0, 0, 0, 0, 0, 0, "lb_lw");
        step(11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "lb_beq_stall1");
        step(11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "lb_beq_stall2");
        step(11, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, "lb_beq_go");
        nop(0, "lb_n1"); nop(0, "lb_n2"); nop(0, "lb_n3");

        // $0 is never a hazard nor a forward source.
        step(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "z_addu0");
        step(0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "z_or");
        nop(0, "z_n1"); nop(0, "z_n2");

        // Tuse=3 never stalls, even against a load in E; unready M never forwards.
        step(29, 0, 1, 3, 13, 2, 0, 0, 0, 0, 0, 0, 0, "tu_lw");
        step(13, 13, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, "tu_nouse");
        nop(0, "tu_n1"); nop(0, "tu_n2"); nop(0, "tu_n3");

        // mult enters E at t; mflo from t+1 stalls through t+4, goes at t+5.
        step(1, 2, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, "md_mult");
        nop(1, "md_t");
        for (int i = 1; i <= 4; i++)
            step(0, 0, 3, 3, 12, 1, 2'b11, 1, 0, 0, 0, 0, 1, $sformatf("md_mflo_t%0d", i));
        step(0, 0, 3, 3, 12, 1, 2'b11, 0, 0, 0, 0, 0, 0, "md_mflo_go");
        nop(0, "md_n1"); nop(0, "md_n2"); nop(0, "md_n3");

        // div: busy exactly 10 cycles; mtlo at the last busy cycle stalls once.
        step(1, 2, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, "dv_div");
        for (int i = 0; i <= 8; i++)
            nop(1, $sformatf("dv_busy_t%0d", i));
        step(0, 0, 3, 3, 0, 0, 2'b11, 1, 0, 0, 0, 0, 1, "dv_mtlo_stall");
        step(0, 0, 3, 3, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, "dv_mtlo_go");
        nop(0, "dv_n1");

        // A stalled div must not reload; reset clears a running div at once.
        step(1, 2, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, "sm_mult");
        for (int i = 0; i <= 3; i++)
            nop(1, $sformatf("sm_busy_t%0d", i));
        step(1, 2, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, 1, "sm_div_stall");
        step(1, 2, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, "sm_div_go");
        nop(1, "sm_div_busy1"); nop(1, "sm_div_busy2");
        reset = 1'b0;
        nop(1, "sm_reset_cycle");
        reset = 1'b1;
        nop(0, "sm_after_reset"); nop(0, "sm_n1");

        @(negedge clk);
        check("queue_drained", {1'b0, q.size() == 0}, 2'b01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipelined MIPS core.
- Keeps a shadow pipeline of destination register, Tnew and source registers for stages E/M/W.
- From it, generates the stall signal plus select codes for the four forwarding muxes: D-stage rs/rt for branch compare, and E-stage rs/rt for the ALU.
- Also owns the multiply/divide busy counter that serialises mult/div/HI-LO instructions.

Parameters:
- MULT_LAT, 5: busy cycles for mult/multu.
- DIV_LAT, 10: busy cycles for div/divu.
- CNT_W, 4: counter width; must hold DIV_LAT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- D_rs  input  5  rs field of the instruction in D.
- D_rt  input  5  rt field of the instruction in D.
- D_Tuse_rs  input  2  cycles until rs is needed; 0, 1 or 2; 3 = not used.
- D_Tuse_rt  input  2  same encoding for rt.
- D_A3  input  5  destination register of the D instruction; 0 = no write.
- D_Tnew  input  2  cycles after entering E until the result exists: 0 PC+8, 1 ALU, 2 load.
- D_md_op  input  2  00 none, 01 mult/multu, 10 div/divu, 11 mfhi/mflo/mthi/mtlo.
- stall  output  1  freeze PC and F/D, insert bubble into D/E.
- FwdSel_D_rs  output  2  select for the D-stage rs forward mux.
- FwdSel_D_rt  output  2  select for the D-stage rt forward mux.
- FwdSel_E_rs  output  2  select for the E-stage rs forward mux.
- FwdSel_E_rt  output  2  select for the E-stage rt forward mux.
- md_busy  output  1  multiply/divide unit is occupied.

Behaviour:
- Select encoding: 00 origin, 01 M forward, 10 W forward.
- Shadow registers, all updated on the rising clk edge:
  - E_{rs,rt,A3,Tnew,md_op}
  - M_{A3,Tnew}
  - W_A3
- Update when stall=0: E <= D inputs.
- Update when stall=1: E <= bubble (all fields 0).
- Always: M_A3 <= E_A3; M_Tnew <= E_Tnew-1, saturating at 0; W_A3 <= M_A3.
- Reset (reset==0 at the edge): all shadow registers and the counter go to 0. The next cycle therefore shows stall=0, md_busy=0, and all selects 00. Reset overrides a mult/div in progress; the counter is cleared immediately.
- Data-hazard stall for rs:
  - Condition: D_rs!=0 AND ((D_rs==E_A3 AND D_Tuse_rs<E_Tnew) OR (D_rs==M_A3 AND D_Tuse_rs<M_Tnew)).
  - Tuse=3 never stalls.
  - Same rule for rt. W never causes a stall.
- MD stall: D_md_op!=00 AND md_busy.
- stall = rs stall OR rt stall OR MD stall. It is combinational from inputs and registers, with zero latency.
- Forward select for source s vs. stage X (X = M or W):
  - Hit requires s!=0, s==X_A3 and X_A3!=0.
  - An M hit additionally requires M_Tnew==0.
  - M has priority over W; otherwise 00.
  - The D selects use D_rs/D_rt; the E selects use E_rs/E_rt.
- Register 0 never forwards, even if an A3 field equals 0.
- MD counter:
  - Load: on the edge where a D instruction with md_op 01 (load MULT_LAT) or 10 (load DIV_LAT) moves into E, i.e. stall=0.
  - Otherwise, if nonzero, decrement by 1.
  - md_busy = (cnt!=0).
  - Busy lasts exactly LAT cycles, counting the op's E cycle as the first.
  - A second mult/div or HI/LO access in D stalls until the cycle in which cnt==0.
- Simultaneous events:
  - A stalled md op does not load the counter.
  - A load while the counter is nonzero cannot occur, because a stall blocks it.
  - Data stall and MD stall together produce a single stall.

Decomposition:
- Forward select constants (origin=2'b00, M_Forward=2'b01, W_Forward=2'b10) go in the shared macro header, used by both this block and the forward muxes.
- md_op encodings and Tnew/Tuse encodings go in the same header.
- One natural sub-module: md_busy_counter, holding the load/decrement counter and md_busy.

Test Plan:
- Reset: hold reset=0 for 2 cycles with D_rs=D_A3=5 -> the first cycle after release shows stall=0, all selects 00, md_busy=0.
- Load-use: cycle 0 D: lw $8 (A3=8, Tnew=2). Cycle 1 D: add rs=8 (Tuse_rs=1) -> stall=1 for 1 cycle. Then stall=0 with FwdSel_E_rs=10 (W) in the cycle add is in E.
- ALU-ALU: addu $3 followed by subu rs=3 (Tuse=1) -> no stall. FwdSel_E_rs=01 (M) when subu is in E.
- Branch dependency: addu $4 then beq rs=4 (Tuse=0) -> stall=1 for 1 cycle, then FwdSel_D_rs=01.
- $0 guard: addu $0 then or rs=0 -> stall=0; all selects 00 throughout.
- MDU: mult enters E at cycle t, mflo in D at t+1 -> md_busy=1 for cycles t..t+4 and stall=1 for t+1..t+4. mflo enters E at edge t+5. A div enters E at t -> busy for 10 cycles.
